nco_config_ctrl: RTL
====================

NCO_CONFIG_CTRL -- requirements
Module: nco_config_ctrl

Interface
REQ-001 SHALL expose parameter DUTY_RST, default 16'h8000, duty_cycle reset/default value (50 %).
REQ-002 SHALL expose parameter FREQ_RST, default 64'h0, frequency reset/default value.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 bus_start  input  1  one-cycle pulse: I2C START or repeated START addressed to this slave.
REQ-006 bus_stop  input  1  one-cycle pulse: I2C STOP.
REQ-007 rx_valid  input  1  one-cycle pulse: rx_data holds a received data byte (after address byte).
REQ-008 rx_data  input  8  received byte, MSB-first assembled.
REQ-009 rx_ack  output  1  registered; 1 = byte accepted (slave should ACK), 0 = NACK.
REQ-010 enable  output  1  active NCO enable.
REQ-011 wave  output  2  active waveform select.
REQ-012 frequency  output  64  active NCO tuning word.
REQ-013 duty_cycle  output  16  active duty-cycle word.
REQ-014 cfg_update  output  1  one-cycle pulse when active registers change.
REQ-015 cfg_error  output  1  one-cycle pulse when a transaction is discarded.

Function
REQ-016 SHALL implement FSM states IDLE, PTR, DATA, DROP.
REQ-017 IDLE: bus_start -> PTR; rx_valid ignored, rx_ack=0.
REQ-018 PTR: first rx_valid is register pointer; 0x00 CTRL (len 1), 0x01 FREQ (len 8), 0x02 DUTY (len 2); valid pointer -> DATA, clear byte counter, rx_ack=1; other pointer -> DROP, rx_ack=0.
REQ-019 CTRL byte format: bit0 enable, bits[2:1] wave, bits[7:3] ignored.
REQ-020 DATA: each rx_valid shifts byte into shadow register MSB-first (shadow = {shadow[len*8-9:0], rx_data}), counter increments, rx_ack=1.
REQ-021 DATA: rx_valid when counter already equals register length -> overrun: DROP, rx_ack=0, shadow discarded.
REQ-022 DROP: all further bytes NACKed (rx_ack=0) until bus_stop or bus_start.
REQ-023 rx_ack SHALL update the cycle after rx_valid and hold until next rx_valid.
REQ-024 bus_stop in DATA with counter == length: copy shadow to active output one cycle later, pulse cfg_update that same cycle, -> IDLE.
REQ-025 bus_stop in DATA with 0 < counter < length: no change, pulse cfg_error, -> IDLE.
REQ-026 bus_stop in DATA with counter == 0 (pointer only): no change, no pulse, -> IDLE.
REQ-027 bus_stop in DROP: pulse cfg_error, -> IDLE; bus_stop in PTR or IDLE: -> IDLE, no pulses.
REQ-028 bus_start in PTR/DATA/DROP (repeated START): discard shadow, no commit, no cfg_error, -> PTR.
REQ-029 rx_valid and bus_stop same cycle: byte processed first, then stop evaluated with updated counter.
REQ-030 bus_start and bus_stop same cycle: bus_stop first, then bus_start (ends in PTR).
REQ-031 Active outputs SHALL change only on commit; multi-byte registers update atomically (all bits same cycle).
REQ-032 cfg_update and cfg_error SHALL never assert together.

Reset
REQ-033 rst SHALL force IDLE, enable=0, wave=2'b00, frequency=FREQ_RST, duty_cycle=DUTY_RST, rx_ack=0, cfg_update=0, cfg_error=0, counter and shadows 0.
REQ-034 rst mid-transaction SHALL abandon it without commit or error pulse; bytes before next bus_start are ignored.

Verification
REQ-035 start, 0x01, 00 00 01 D4 C0 00 00 00, stop -> frequency=64'h000001D4C0000000 one cycle after stop, cfg_update 1 cycle, all 9 bytes ACKed.
REQ-036 start, 0x02, FA CE, stop -> duty_cycle=16'hFACE, cfg_update; then start, 0x00, 0x05, stop -> enable=1, wave=2'b10.
REQ-037 start, 0x01, 4 bytes, stop -> frequency unchanged, cfg_error 1 cycle, no cfg_update.
REQ-038 start, 0x02, 3 bytes -> third byte NACKed; stop -> cfg_error, duty_cycle unchanged; start, 0x07 -> NACK, later bytes NACKed.
REQ-039 start, 0x01, 3 bytes, repeated start, 0x02, AB CD, stop -> duty_cycle=16'hABCD, frequency unchanged, no cfg_error.
REQ-040 start, 0x01, 5 bytes, rst, then stop -> all outputs at reset values, no pulses.

Source files
------------

// File: rtl/nco_config_ctrl_if.sv
// Byte-level I2C slave link between the bus front end and the NCO register block.
// The front end drives framing pulses and received bytes; the register block answers with ACK/NACK.
interface nco_config_ctrl_if;
  logic       bus_start;
  logic       bus_stop;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ack;

  modport master (
    output bus_start,
    output bus_stop,
    output rx_valid,
    output rx_data,
    input  rx_ack
  );

  modport slave (
    input  bus_start,
    input  bus_stop,
    input  rx_valid,
    input  rx_data,
    output rx_ack
  );
endinterface

// File: rtl/nco_config_ctrl.sv
// NCO configuration register block behind an I2C byte interface.
// Writes land in a shadow register and only reach the active outputs on a complete, STOP-terminated write.
module nco_config_ctrl #(
  parameter logic [15:0] DUTY_RST = 16'h8000,
  parameter logic [63:0] FREQ_RST = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  nco_config_ctrl_if.slave     bus,
  output logic                 enable,
  output logic [1:0]           wave,
  output logic [63:0]          frequency,
  output logic [15:0]          duty_cycle,
  output logic                 cfg_update,
  output logic                 cfg_error
);

  typedef enum logic [1:0] {IDLE, PTR, DATA, DROP} state_t;
  typedef enum logic [1:0] {REG_CTRL = 2'd0, REG_FREQ = 2'd1, REG_DUTY = 2'd2} reg_t;

  state_t      state_q, state_d;
  reg_t        sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] shadow_q, shadow_d;
  logic        rx_ack_q, rx_ack_d;
  logic        enable_q, enable_d;
  logic [1:0]  wave_q, wave_d;
  logic [63:0] freq_q, freq_d;
  logic [15:0] duty_q, duty_d;
  logic        upd_q, upd_d;
  logic        err_q, err_d;

  function automatic logic [3:0] reg_len(input reg_t sel);
    case (sel)
      REG_FREQ: reg_len = 4'd8;
      REG_DUTY: reg_len = 4'd2;
      default:  reg_len = 4'd1;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= REG_CTRL;
      cnt_q    <= 4'd0;
      shadow_q <= 64'd0;
      rx_ack_q <= 1'b0;
      enable_q <= 1'b0;
      wave_q   <= 2'b00;
      freq_q   <= FREQ_RST;
      duty_q   <= DUTY_RST;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      rx_ack_q <= rx_ack_d;
      enable_q <= enable_d;
      wave_q   <= wave_d;
      freq_q   <= freq_d;
      duty_q   <= duty_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  // Same-cycle events resolve in order: byte, then STOP, then START.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    rx_ack_d = rx_ack_q;
    enable_d = enable_q;
    wave_d   = wave_q;
    freq_d   = freq_q;
    duty_d   = duty_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;

    if (bus.rx_valid) begin
      case (state_q)
        PTR: begin
          if (bus.rx_data == 8'h00 || bus.rx_data == 8'h01 || bus.rx_data == 8'h02) begin
            state_d  = DATA;
            sel_d    = reg_t'(bus.rx_data[1:0]);
            cnt_d    = 4'd0;
            shadow_d = 64'd0;
            rx_ack_d = 1'b1;
          end else begin
            state_d  = DROP;
            rx_ack_d = 1'b0;
          end
        end
        DATA: begin
          if (cnt_q == reg_len(sel_q)) begin
            state_d  = DROP;
            cnt_d    = 4'd0;
            shadow_d = 64'd0;
            rx_ack_d = 1'b0;
          end else begin
            shadow_d = {shadow_q[55:0], bus.rx_data};
            cnt_d    = cnt_q + 4'd1;
            rx_ack_d = 1'b1;
          end
        end
        default: rx_ack_d = 1'b0;
      endcase
    end

    if (bus.bus_stop) begin
      if (state_d == DATA) begin
        if (cnt_d == reg_len(sel_d)) begin
          upd_d = 1'b1;
          case (sel_d)
            REG_CTRL: begin
              enable_d = shadow_d[0];
              wave_d   = shadow_d[2:1];
            end
            REG_FREQ: freq_d = shadow_d;
            REG_DUTY: duty_d = shadow_d[15:0];
            default: ;
          endcase
        end else if (cnt_d != 4'd0) begin
          err_d = 1'b1;
        end
      end else if (state_d == DROP) begin
        err_d = 1'b1;
      end
      state_d  = IDLE;
      cnt_d    = 4'd0;
      shadow_d = 64'd0;
    end

    if (bus.bus_start) begin
      state_d  = PTR;
      cnt_d    = 4'd0;
      shadow_d = 64'd0;
    end
  end

  assign bus.rx_ack = rx_ack_q;
  assign enable     = enable_q;
  assign wave       = wave_q;
  assign frequency  = freq_q;
  assign duty_cycle = duty_q;
  assign cfg_update = upd_q;
  assign cfg_error  = err_q;

endmodule
